apple_spawner: RTL and testbench

- Sits between the snake movement logic and the VGA rectangle renderer. It replaces the free-running apple generator.
- Detects when the snake head lands on the apple and emits a one-cycle grow strobe to the movement logic.
- Picks a new apple position with an LFSR and rejects any candidate that is off-grid or on any valid snake segment.
- Keeps a saturating score.

---
 rtl/apple_spawner_if.sv | 28 ++
 rtl/apple_spawner.sv | 194 +++++++++++++++++++
 tb/tb_apple_spawner.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apple_spawner_if.sv
// Snake-side bus of the apple spawner: body snapshot in, apple/grow/score out.
interface apple_spawner_if #(
  parameter int unsigned SEGMENTS = 10
);
  localparam int unsigned SEG_W = 11;

  logic                        move_pulse;
  logic [SEG_W*SEGMENTS-1:0]   snake_flat;
  logic [3:0]                  snake_len;
  logic [5:0]                  apple_x;
  logic [4:0]                  apple_y;
  logic                        apple_valid;
  logic                        grow;
  logic [7:0]                  score;
  logic                        busy;

  // Movement logic side.
  modport master (
    output move_pulse, snake_flat, snake_len,
    input  apple_x, apple_y, apple_valid, grow, score, busy
  );

  // Apple spawner side.
  modport slave (
    input  move_pulse, snake_flat, snake_len,
    output apple_x, apple_y, apple_valid, grow, score, busy
  );
endinterface

// File: rtl/apple_spawner.sv
// Apple spawner: eat detection, grow strobe, saturating score and LFSR-based
// respawn that rejects off-grid and on-body candidates, falling back to a
// raster sweep after too many rejections.
module apple_spawner #(
  parameter int unsigned GRID_W    = 40,
  parameter int unsigned GRID_H    = 30,
  parameter int unsigned SEGMENTS  = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned INIT_X    = 30,
  parameter int unsigned INIT_Y    = 10,
  parameter int unsigned MAX_TRIES = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  apple_spawner_if.slave sp
);

  localparam int unsigned X_W    = 6;
  localparam int unsigned Y_W    = 5;
  localparam int unsigned SEG_W  = X_W + Y_W;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned SLOTS  = 1 << IDX_W;
  localparam int unsigned NSEG   = (SEGMENTS < SLOTS) ? SEGMENTS : SLOTS;
  localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int unsigned SCORE_W = 8;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
  } coord_t;

  typedef enum logic [1:0] {
    S_HOLD,
    S_GEN,
    S_SCAN,
    S_COMMIT
  } state_e;

  state_e               state_q,  state_d;
  logic [15:0]          lfsr_q,   lfsr_d;
  logic [TRY_W-1:0]     try_q,    try_d;
  coord_t               sweep_q,  sweep_d;
  coord_t               cand_q,   cand_d;
  logic [IDX_W-1:0]     idx_q,    idx_d;
  logic                 pend_q,   pend_d;
  coord_t               apple_q,  apple_d;
  logic                 valid_q,  valid_d;
  logic                 grow_q,   grow_d;
  logic [SCORE_W-1:0]   score_q,  score_d;
  logic                 busy_q,   busy_d;

  coord_t               seg_a [SLOTS];
  coord_t               seg_cur;
  coord_t               gen_c;
  logic                 sweep_mode;
  logic                 gen_in_range;
  logic [IDX_W-1:0]     last_idx;
  logic [TRY_W-1:0]     try_inc;
  logic [15:0]          lfsr_adv;
  coord_t               sweep_adv;

  // Unpack the body snapshot; unused slots read as zero and are never scanned.
  always_comb begin
    for (int i = 0; i < int'(SLOTS); i++) begin
      seg_a[i] = '0;
    end
    for (int i = 0; i < int'(NSEG); i++) begin
      seg_a[i] = coord_t'(sp.snake_flat[SEG_W*i +: SEG_W]);
    end
  end

  // Helper terms shared by the next-state logic.
  always_comb begin
    seg_cur      = seg_a[idx_q];
    last_idx     = (32'(sp.snake_len) >= NSEG) ? IDX_W'(NSEG - 1) : sp.snake_len;
    try_inc      = (try_q == TRY_W'(MAX_TRIES)) ? try_q : try_q + TRY_W'(1);
    lfsr_adv     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    sweep_mode   = (try_q == TRY_W'(MAX_TRIES));
    gen_c.x      = sweep_mode ? sweep_q.x : lfsr_q[5:0];
    gen_c.y      = sweep_mode ? sweep_q.y : lfsr_q[12:8];
    gen_in_range = (32'(gen_c.x) < GRID_W) && (32'(gen_c.y) < GRID_H);
    sweep_adv    = sweep_q;
    if (sweep_q.x == X_W'(GRID_W - 1)) begin
      sweep_adv.x = '0;
      sweep_adv.y = (sweep_q.y == Y_W'(GRID_H - 1)) ? '0 : sweep_q.y + Y_W'(1);
    end else begin
      sweep_adv.x = sweep_q.x + X_W'(1);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_adv;
    try_d   = try_q;
    sweep_d = sweep_q;
    cand_d  = cand_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    apple_d = apple_q;
    valid_d = valid_q;
    grow_d  = 1'b0;
    score_d = score_q;

    case (state_q)
      S_HOLD: begin
        pend_d = 1'b0;
        if ((sp.move_pulse || pend_q) && valid_q && (seg_a[0] == apple_q)) begin
          grow_d  = 1'b1;
          score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
          valid_d = 1'b0;
          try_d   = '0;
          state_d = S_GEN;
        end
      end
      S_GEN: begin
        if (sweep_mode) begin
          sweep_d = sweep_adv;
        end
        if (gen_in_range) begin
          cand_d  = gen_c;
          idx_d   = '0;
          state_d = S_SCAN;
        end else begin
          try_d = try_inc;
        end
      end
      S_SCAN: begin
        if (sp.move_pulse) begin
          idx_d = '0;
        end else if (seg_cur == cand_q) begin
          try_d   = try_inc;
          state_d = S_GEN;
        end else if (idx_q == last_idx) begin
          state_d = S_COMMIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_COMMIT: begin
        apple_d = cand_q;
        valid_d = 1'b1;
        pend_d  = sp.move_pulse;
        state_d = S_HOLD;
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase

    busy_d = (state_d != S_HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_HOLD;
      lfsr_q  <= LFSR_SEED;
      try_q   <= '0;
      sweep_q <= '0;
      cand_q  <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      apple_q <= coord_t'({Y_W'(INIT_Y), X_W'(INIT_X)});
      valid_q <= 1'b1;
      grow_q  <= 1'b0;
      score_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      try_q   <= try_d;
      sweep_q <= sweep_d;
      cand_q  <= cand_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      apple_q <= apple_d;
      valid_q <= valid_d;
      grow_q  <= grow_d;
      score_q <= score_d;
      busy_q  <= busy_d;
    end
  end

  // Drive the bus straight from the registers.
  assign sp.apple_x     = apple_q.x;
  assign sp.apple_y     = apple_q.y;
  assign sp.apple_valid = valid_q;
  assign sp.grow        = grow_q;
  assign sp.score       = score_q;
  assign sp.busy        = busy_q;

endmodule

// File: tb/tb_apple_spawner.sv
// Directed bench for apple_spawner: reset, eat, miss, body rejection,
// mid-scan move, sweep fallback, score saturation and async reset.
module tb_apple_spawner;
  localparam int unsigned SEGS = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  apple_spawner_if #(.SEGMENTS(SEGS)) bus ();
  apple_spawner_if #(.SEGMENTS(SEGS)) bus_sw ();

  apple_spawner #(.SEGMENTS(SEGS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sp      (bus.slave)
  );

  apple_spawner #(.SEGMENTS(SEGS), .INIT_X(0), .INIT_Y(0), .MAX_TRIES(1)) dut_sw (
    .clk     (clk),
    .reset_n (reset_n),
    .sp      (bus_sw.slave)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Reference LFSR, free-running like the one in the design.
  logic [15:0] lfsr_m;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_m <= 16'hACE1;
    else          lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] xy(input int x, input int y);
    return {5'(y), 6'(x)};
  endfunction

  function automatic logic [15:0] adv(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic in_rng(input logic [15:0] l);
    return (l[5:0] < 6'd40) && (l[12:8] < 5'd30);
  endfunction

  logic [11*SEGS-1:0] flat;
  logic [3:0]         len;

  function automatic logic on_body(input logic [10:0] p, input int n);
    logic hit = 1'b0;
    for (int i = 0; i <= n; i++) if (flat[11*i +: 11] == p) hit = 1'b1;
    return hit;
  endfunction

  // First in-range LFSR candidate seen by GEN after an eat on the next edge,
  // and how many GEN cycles it takes to reach it.
  task automatic first_cand(output logic [10:0] c, output int k);
    logic [15:0] l;
    l = lfsr_m;
    k = 0;
    do begin
      l = adv(l);
      k++;
    end while (!in_rng(l));
    c = {l[12:8], l[5:0]};
  endtask

  task automatic pulse_main();
    bus.snake_flat = flat;
    bus.snake_len  = len;
    bus.move_pulse = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.move_pulse = 1'b0;
  endtask

  task automatic wait_valid(input bit sw, inout int lat, output bit ok);
    ok = 1'b1;
    while (!(sw ? bus_sw.apple_valid : bus.apple_valid)) begin
      if (lat >= 200) begin
        ok = 1'b0;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  logic [10:0] c, ap, nh, ap_now;
  int          k, lat, r, exp_score;
  bit          ok, found, grow_seen, changed, all_ok, grow_ok;
  logic [7:0]  score_save;

  initial begin
    #600000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bus.move_pulse = 1'b0; bus.snake_flat = '0; bus.snake_len = '0;
    bus_sw.move_pulse = 1'b0; bus_sw.snake_flat = '0; bus_sw.snake_len = '0;
    flat = '0; len = '0; exp_score = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_x", bus.apple_x, 30);
    check("rst_y", bus.apple_y, 10);
    check("rst_valid", bus.apple_valid, 1);
    check("rst_score", bus.score, 0);
    check("rst_grow", bus.grow, 0);
    check("rst_busy", bus.busy, 0);

    // Eat with a two-segment snake
    flat = '0; flat[10:0] = xy(30, 10); flat[21:11] = xy(29, 10); len = 4'd1;
    first_cand(c, k);
    pulse_main(); lat = 1; exp_score++;
    check("eat_grow", bus.grow, 1);
    check("eat_score", bus.score, 32'(exp_score));
    check("eat_valid", bus.apple_valid, 0);
    check("eat_busy", bus.busy, 1);
    @(negedge clk); lat++;
    check("eat_grow_once", bus.grow, 0);
    wait_valid(1'b0, lat, ok);
    check("eat_respawn", ok, 1);
    ap_now = {bus.apple_y, bus.apple_x};
    check("eat_x_rng", bus.apple_x < 6'd40, 1);
    check("eat_y_rng", bus.apple_y < 5'd30, 1);
    check("eat_off_body", on_body(ap_now, 1), 0);
    if (!on_body(c, 1)) begin
      check("eat_apple", ap_now, c);
      check("eat_latency", lat, k + 4);
    end
    check("eat_idle", bus.busy, 0);

    // Miss: head elsewhere, nothing may change
    ap = {bus.apple_y, bus.apple_x};
    nh = (ap == xy(5, 5)) ? xy(6, 5) : xy(5, 5);
    flat = '0; flat[10:0] = nh; len = 4'd1;
    score_save = bus.score;
    pulse_main();
    grow_seen = 1'b0; changed = 1'b0;
    repeat (100) begin
      if (bus.grow) grow_seen = 1'b1;
      if ({bus.apple_y, bus.apple_x} != ap || bus.score != score_save || !bus.apple_valid)
        changed = 1'b1;
      @(negedge clk);
    end
    check("miss_grow", grow_seen, 0);
    check("miss_changed", changed, 0);

    // Body rejection: segment 3 sits on the first in-range candidate
    first_cand(c, k);
    ap = {bus.apple_y, bus.apple_x};
    flat = '0; flat[10:0] = ap; flat[21:11] = xy(0, 29); flat[32:22] = xy(1, 29);
    flat[43:33] = c; len = 4'd3;
    pulse_main(); lat = 1; exp_score++;
    check("rej_grow", bus.grow, 1);
    wait_valid(1'b0, lat, ok);
    check("rej_respawn", ok, 1);
    ap_now = {bus.apple_y, bus.apple_x};
    check("rej_regen", lat > k + 6, 1);
    check("rej_not_c", ap_now != c, 1);
    check("rej_off_body", on_body(ap_now, 3), 0);
    check("rej_rng", (bus.apple_x < 6'd40) && (bus.apple_y < 5'd30), 1);

    // Mid-scan move: pick an eat cycle whose first candidate is accepted
    found = 1'b0;
    for (int t = 0; t < 2000 && !found; t++) begin
      first_cand(c, k);
      ap = {bus.apple_y, bus.apple_x};
      nh = xy(int'(ap[5:0]), (int'(ap[10:6]) + 1) % 30);
      if (k == 1 && c != ap && c != nh) found = 1'b1;
      else @(negedge clk);
    end
    check("mid_setup", found, 1);
    r = (int'(c[10:6]) + 1) % 30;
    flat = '0; flat[10:0] = ap;
    for (int i = 1; i < 10; i++) flat[11*i +: 11] = xy(i, r);
    len = 4'd9;
    pulse_main(); lat = 1; exp_score++;
    repeat (3) begin @(negedge clk); lat++; end
    check("mid_busy", bus.busy, 1);
    for (int i = 9; i >= 1; i--) flat[11*i +: 11] = flat[11*(i-1) +: 11];
    flat[10:0] = nh;
    bus.snake_flat = flat;
    bus.move_pulse = 1'b1;
    @(negedge clk); lat++;
    bus.move_pulse = 1'b0;
    wait_valid(1'b0, lat, ok);
    check("mid_respawn", ok, 1);
    check("mid_latency", lat, 16);
    check("mid_apple", {bus.apple_y, bus.apple_x}, c);
    check("mid_score", bus.score, 32'(exp_score));

    // Sweep fallback on the MAX_TRIES=1 instance: first candidate off-grid
    found = 1'b0;
    for (int t = 0; t < 2000 && !found; t++) begin
      if (!in_rng(adv(lfsr_m))) found = 1'b1;
      else @(negedge clk);
    end
    check("sw_setup", found, 1);
    flat = '0;
    for (int j = 0; j < 4; j++) flat[11*j +: 11] = xy(j, 0);
    bus_sw.snake_flat = flat; bus_sw.snake_len = 4'd3; bus_sw.move_pulse = 1'b1;
    @(posedge clk); @(negedge clk);
    bus_sw.move_pulse = 1'b0; lat = 1;
    check("sw_grow", bus_sw.grow, 1);
    wait_valid(1'b1, lat, ok);
    check("sw_respawn", ok, 1);
    check("sw_x", bus_sw.apple_x, 4);
    check("sw_y", bus_sw.apple_y, 0);
    check("sw_latency", lat, 22);
    check("sw_score", bus_sw.score, 1);

    // Score saturation
    all_ok = 1'b1; grow_ok = 1'b1;
    for (int e = 0; e < 260; e++) begin
      flat = '0; flat[10:0] = {bus.apple_y, bus.apple_x}; len = 4'd0;
      pulse_main(); lat = 1;
      if (!bus.grow) grow_ok = 1'b0;
      exp_score = (exp_score < 255) ? exp_score + 1 : 255;
      wait_valid(1'b0, lat, ok);
      if (!ok) all_ok = 1'b0;
    end
    check("sat_respawn", all_ok, 1);
    check("sat_grow", grow_ok, 1);
    check("sat_score", bus.score, 32'(exp_score));
    check("sat_255", bus.score, 255);

    // Asynchronous reset in the middle of a scan
    ap = {bus.apple_y, bus.apple_x};
    flat = '0; flat[10:0] = ap;
    for (int i = 1; i < 10; i++) flat[11*i +: 11] = xy(i + 20, 29);
    len = 4'd9;
    pulse_main();
    @(negedge clk);
    check("ar_busy_before", bus.busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_x", bus.apple_x, 30);
    check("ar_y", bus.apple_y, 10);
    check("ar_valid", bus.apple_valid, 1);
    check("ar_grow", bus.grow, 0);
    check("ar_score", bus.score, 0);
    check("ar_busy", bus.busy, 0);
    check("ar_sw_x", bus_sw.apple_x, 0);
    check("ar_sw_score", bus_sw.score, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ar_after_busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
